// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: walks NUM_OUT neurons over N_FEAT
// features, multiply-accumulating buffer data against weights, and hands
// each dot product downstream through a valid/ready result port.
module fc_sequencer #(
  parameter int N_FEAT  = 225,
  parameter int NUM_OUT = 10,
  parameter int W_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_buffer_full,
  output logic [7:0]                o_rd_addr,
  input  logic signed [21:0]        i_rd_data,
  output logic [11:0]               o_w_addr,
  input  logic signed [W_WIDTH-1:0] i_weight,
  output logic signed [39:0]        o_result,
  output logic                      o_result_valid,
  input  logic                      i_result_ready,
  output logic [3:0]                o_neuron_idx,
  output logic                      o_done,
  output logic                      o_buffer_clear
);

  typedef enum logic [1:0] {IDLE, MAC, OUTPUT, DONE} state_t;

  localparam int          PW          = 22 + W_WIDTH;
  localparam logic [7:0]  LAST_FEAT   = 8'(N_FEAT - 1);
  localparam logic [3:0]  LAST_NEUR   = 4'(NUM_OUT - 1);
  localparam logic [11:0] FEAT_STRIDE = 12'(N_FEAT);

  state_t state, state_nxt;

  logic [7:0]         feature;
  logic [3:0]         neuron;
  logic signed [39:0] acc;

  // Full-precision signed product, then sign-extended into the 40-bit
  // accumulator domain; 225 * 2^28 cannot overflow 40 bits, so no saturation.
  logic signed [PW-1:0] data_ext, wt_ext, prod;
  logic signed [39:0]   prod_ext;

  assign data_ext = PW'(i_rd_data);
  assign wt_ext   = PW'(i_weight);
  assign prod     = data_ext * wt_ext;
  assign prod_ext = 40'(prod);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; full is only looked at in IDLE, ready only in OUTPUT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_buffer_full) state_nxt = MAC;
      MAC:     if (feature == LAST_FEAT) state_nxt = OUTPUT;
      OUTPUT:  if (i_result_ready) state_nxt = (neuron == LAST_NEUR) ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath counters and accumulator; the last feature is accumulated without
  // advancing the index so MAC lasts exactly N_FEAT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      feature <= '0;
      neuron  <= '0;
    end else begin
      case (state)
        IDLE: if (i_buffer_full) begin
          acc     <= '0;
          feature <= '0;
          neuron  <= '0;
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (feature != LAST_FEAT) feature <= feature + 8'd1;
        end
        OUTPUT: if (i_result_ready && neuron != LAST_NEUR) begin
          acc     <= '0;
          feature <= '0;
          neuron  <= neuron + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_addr      = feature;
  assign o_w_addr       = FEAT_STRIDE * 12'(neuron) + 12'(feature);
  assign o_result       = acc;
  assign o_neuron_idx   = neuron;
  assign o_result_valid = (state == OUTPUT);
  assign o_done         = (state == DONE);
  assign o_buffer_clear = (state == DONE);

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: a table of data/weight patterns with
// hand-computed per-neuron results, plus hand-written ready-stall, mid-run
// reset and idle-hold sequences.
module tb_fc_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               full;
  logic [7:0]         o_rd_addr;
  logic signed [21:0] rd_data;
  logic [11:0]        o_w_addr;
  logic signed [7:0]  weight;
  logic signed [39:0] o_result;
  logic               o_result_valid;
  logic               ready;
  logic [3:0]         o_neuron_idx;
  logic               o_done;
  logic               o_buffer_clear;

  int errors = 0;
  int checks = 0;

  // dmode: 0 = constant dval, 1 = data equals feature address
  // wmode: 0 = constant wval, 1 = weight equals neuron (o_w_addr / 225)
  typedef struct {
    int     dmode;
    int     dval;
    int     wmode;
    int     wval;
    longint base;
    longint step;
  } vec_t;

  vec_t vecs[7];
  int   cur_dmode, cur_dval, cur_wmode, cur_wval;

  fc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .i_buffer_full  (full),
    .o_rd_addr      (o_rd_addr),
    .i_rd_data      (rd_data),
    .o_w_addr       (o_w_addr),
    .i_weight       (weight),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (ready),
    .o_neuron_idx   (o_neuron_idx),
    .o_done         (o_done),
    .o_buffer_clear (o_buffer_clear)
  );

  always #5 clk = ~clk;

  // Memory model: same-cycle lookup from the addresses the DUT presents
  always_comb begin
    rd_data = (cur_dmode == 1) ? 22'(o_rd_addr) : 22'(cur_dval);
    weight  = (cur_wmode == 1) ? 8'(o_w_addr / 12'd225) : 8'(cur_wval);
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_mode(input int v);
    cur_dmode = vecs[v].dmode;
    cur_dval  = vecs[v].dval;
    cur_wmode = vecs[v].wmode;
    cur_wval  = vecs[v].wval;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; full = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_addr"}, o_rd_addr, 0);
    chk({tag, " w_addr"}, o_w_addr, 0);
    chk({tag, " result"}, o_result, 0);
    chk({tag, " valid"}, o_result_valid, 0);
    chk({tag, " idx"}, o_neuron_idx, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " clear"}, o_buffer_clear, 0);
  endtask

  // Full 10-neuron pass with ready held high; full drops when clear is seen
  task automatic run_vec(input int v);
    int cyc, addr_err, done_cnt, clr_cnt, both_cnt;
    set_mode(v);
    ready = 1'b1;
    @(negedge clk);
    full = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc = 0; addr_err = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!o_result_valid && cyc <= 225) begin
          if (o_rd_addr != 8'(cyc - 1) || o_w_addr != 12'(n * 225 + cyc - 1))
            addr_err++;
        end
      end while (!o_result_valid && cyc < 400);
      chk($sformatf("v%0d n%0d latency", v, n), cyc, 226);
      chk($sformatf("v%0d n%0d result", v, n), o_result, vecs[v].base + vecs[v].step * n);
      chk($sformatf("v%0d n%0d idx", v, n), o_neuron_idx, n);
      chk($sformatf("v%0d n%0d addr_seq", v, n), addr_err, 0);
    end
    done_cnt = 0; clr_cnt = 0; both_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (o_buffer_clear) begin clr_cnt++; full = 1'b0; end
      if (o_done && o_buffer_clear) both_cnt++;
    end
    chk($sformatf("v%0d done_pulses", v), done_cnt, 1);
    chk($sformatf("v%0d clear_pulses", v), clr_cnt, 1);
    chk($sformatf("v%0d done_with_clear", v), both_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, act;
    vecs[0] = '{0, 1,        0, 1,    64'sd225,          64'sd0};
    vecs[1] = '{0, -2097152, 0, -128, 64'sd60397977600,  64'sd0};
    vecs[2] = '{0, 1,        1, 0,    64'sd0,            64'sd225};
    vecs[3] = '{0, 3,        0, -5,   -64'sd3375,        64'sd0};
    vecs[4] = '{0, 2097151,  0, 127,  64'sd59926089825,  64'sd0};
    vecs[5] = '{0, -7,       1, 0,    64'sd0,            -64'sd1575};
    vecs[6] = '{1, 0,        0, 1,    64'sd25200,        64'sd0};
    set_mode(0);
    rst = 1'b1; full = 1'b0; ready = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk_zero("reset");

    // Idle hold: full low for 50 cycles, nothing moves
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_rd_addr != 0 || o_w_addr != 0 || o_result_valid || o_done || o_buffer_clear)
        bad++;
    end
    chk("idle_hold activity", bad, 0);

    // Table-driven passes
    for (int v = 0; v < 7; v++) begin
      do_reset();
      run_vec(v);
    end

    // Ready stall: result and addresses frozen while ready is low
    do_reset();
    set_mode(0);
    ready = 1'b0;
    @(negedge clk);
    full = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!o_result_valid && cyc < 400);
    chk("stall first_valid latency", cyc, 226);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bad = 0;
      if (!o_result_valid) bad++;
      if (o_result != 40'sd225) bad++;
      if (o_neuron_idx != 0) bad++;
      if (o_rd_addr != 8'd224 || o_w_addr != 12'd224) bad++;
      chk($sformatf("stall hold cycle%0d", k), bad, 0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("stall release valid", o_result_valid, 0);
    chk("stall release idx", o_neuron_idx, 1);
    chk("stall release rd_addr", o_rd_addr, 0);
    chk("stall release w_addr", o_w_addr, 225);

    // Reset mid-MAC at feature 100 of neuron 3, then a clean restart
    do_reset();
    set_mode(0);
    ready = 1'b1;
    @(negedge clk);
    full = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(o_neuron_idx == 4'd3 && o_rd_addr == 8'd100) && cyc < 2000);
    chk("midreset reached n3 f100", (o_neuron_idx == 4'd3 && o_rd_addr == 8'd100) ? 1 : 0, 1);
    chk("midreset w_addr", o_w_addr, 775);
    act = 0;
    rst = 1'b1; full = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_done || o_buffer_clear || o_result_valid || o_rd_addr != 0) act++;
    end
    chk("midreset idle activity", act, 0);
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 The block SHALL have parameter N_FEAT, default 225: number of flattened features per neuron.
REQ-002 The block SHALL have parameter NUM_OUT, default 10: number of output neurons.
REQ-003 The block SHALL have parameter W_WIDTH, default 8: signed weight width.
REQ-004 Port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_buffer_full, input, 1: flatten buffer holds N_FEAT valid entries.
REQ-007 Port o_rd_addr, output, 8: feature index into the flatten buffer.
REQ-008 Port i_rd_data, input, 22 signed: feature at o_rd_addr, valid in the same cycle (combinational mux).
REQ-009 Port o_w_addr, output, 12: weight index, neuron*N_FEAT + feature.
REQ-010 Port i_weight, input, W_WIDTH signed: weight at o_w_addr, valid in the same cycle.
REQ-011 Port o_result, output, 40 signed: dot product for the current neuron.
REQ-012 Port o_result_valid, output, 1: o_result is valid.
REQ-013 Port i_result_ready, input, 1: downstream accepts the result.
REQ-014 Port o_neuron_idx, output, 4: neuron index of the MAC or result in progress.
REQ-015 Port o_done, output, 1: one-cycle pulse when all NUM_OUT results have been accepted.
REQ-016 Port o_buffer_clear, output, 1: one-cycle pulse; drives the flatten buffer synchronous reset.

Function
REQ-017 The FSM SHALL have states IDLE, MAC, OUTPUT, DONE.
REQ-018 In IDLE with i_buffer_full=1, the FSM SHALL go to MAC next cycle, with feature=0, neuron=0, acc=0.
REQ-019 In IDLE with i_buffer_full=0, the FSM SHALL hold all state.
REQ-020 In MAC, each cycle SHALL do acc <= acc + i_rd_data*i_weight (22xW_WIDTH full-precision signed product, sign-extended to 40 bits), then feature++.
REQ-021 In MAC, o_rd_addr SHALL equal feature and o_w_addr SHALL equal neuron*N_FEAT+feature.
REQ-022 When feature==N_FEAT-1 is accumulated, the FSM SHALL go to OUTPUT without incrementing feature; MAC therefore lasts exactly N_FEAT cycles.
REQ-023 The accumulator SHALL use no saturation: worst case 225*2^28 < 2^39.
REQ-024 In OUTPUT, o_result_valid SHALL be 1 and o_result SHALL equal acc, held stable until i_result_ready=1.
REQ-025 On an OUTPUT cycle with i_result_ready=1 and neuron<NUM_OUT-1: neuron++, feature=0, acc=0, next state MAC.
REQ-026 On an OUTPUT cycle with i_result_ready=1 and neuron==NUM_OUT-1: next state DONE.
REQ-027 DONE SHALL last one cycle with o_done=1 and o_buffer_clear=1, then go to IDLE; the buffer deasserts full on the same edge, so there is no retrigger.
REQ-028 i_buffer_full SHALL be ignored outside IDLE.
REQ-029 i_result_ready SHALL be ignored outside OUTPUT.
REQ-030 o_result_valid, o_done and o_buffer_clear SHALL be 0 in all other states.
REQ-031 Latency, with ready held at 1: first o_result_valid 1+N_FEAT cycles after full is sampled in IDLE; each subsequent neuron takes N_FEAT+1 cycles.

Reset
REQ-032 On rst=1 at a clock edge, state SHALL be IDLE and acc, feature, neuron SHALL be 0.
REQ-033 On rst=1, o_rd_addr=0, o_w_addr=0, o_result=0, o_result_valid=0, o_neuron_idx=0, o_done=0, o_buffer_clear=0.
REQ-034 rst SHALL take priority over all other inputs in any state, including mid-MAC and mid-OUTPUT; the partial accumulation is discarded and no o_done is issued.

Verification
REQ-035 Data=1 and weight=1 everywhere, ready=1, full asserted -> 10 results of 225, neuron_idx 0..9, first valid 226 cycles after full; o_done and o_buffer_clear pulse together once.
REQ-036 Data=-2097152 and weight=-128 everywhere -> each result = 60397977600, with no wrap.
REQ-037 Data=1 and weight=neuron index -> result n = 225*n; check o_w_addr = n*225+i throughout.
REQ-038 Hold ready=0 for 5 cycles in OUTPUT -> valid stays 1, o_result and o_neuron_idx stable, o_rd_addr and o_w_addr static; advances on the cycle ready=1.
REQ-039 Assert rst at feature 100 of neuron 3 -> all outputs 0 next cycle, state IDLE; re-assert full -> restart from neuron 0 with correct results.
REQ-040 Hold full=0 for 50 cycles -> no address change, valid, done or clear activity.
